// File: rtl/axi_lite_mem_adapter_if.sv
`default_nettype none
// =============================================================================
// axi_lite_mem_adapter_if : AXI4-Lite bus bundle (AW, W, B, AR, R channels)
// Rev 1.0
// =============================================================================
interface axi_lite_mem_adapter_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_valid;
  logic                        w_ready;
  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic                        b_valid;
  logic                        b_ready;
  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic                        r_valid;
  logic                        r_ready;

  modport master (
    output aw_id, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_id, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
           r_id, r_data, r_resp, r_last, r_valid
  );

  modport slave (
    input  aw_id, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_id, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
           r_id, r_data, r_resp, r_last, r_valid
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_mem_adapter.sv
`default_nettype none
// =============================================================================
// axi_lite_mem_adapter : AXI4-Lite slave to one-cycle memory request bridge.
// Optional address-window SLVERR check: define AXI_LITE_MEM_ADAPTER_ERR_EN.
// Rev 1.0
// =============================================================================
module axi_lite_mem_adapter #(
  parameter int unsigned               AXI_ADDR_WIDTH = 64,
  parameter int unsigned               AXI_DATA_WIDTH = 64,
  parameter int unsigned               AXI_ID_WIDTH   = 10,
  parameter int unsigned               READ_LATENCY   = 1,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BASE      = 'h0,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_SIZE      = 'h1000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  axi_lite_mem_adapter_if.slave         slave,
  output logic                          req_o,
  output logic                          we_o,
  output logic [AXI_ADDR_WIDTH-1:0]     addr_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   be_o,
  output logic [AXI_DATA_WIDTH-1:0]     wdata_o,
  input  logic [AXI_DATA_WIDTH-1:0]     rdata_i
);
  localparam int unsigned STRB_W      = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_W       = $clog2(STRB_W);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_RESP = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } state_e;

  if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
    $error("axi_lite_mem_adapter: READ_LATENCY must be in 1..4");
  end
  if ((AXI_DATA_WIDTH != 32) && (AXI_DATA_WIDTH != 64)) begin : g_bad_width
    $error("axi_lite_mem_adapter: AXI_DATA_WIDTH must be 32 or 64");
  end

  state_e                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                resp_q, resp_d;
  logic                      w_aw_ready, w_ar_ready;
  logic                      w_aw_err, w_ar_err;

  function automatic logic [AXI_ADDR_WIDTH-1:0] word_align(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] r;
    r            = a;
    r[OFF_W-1:0] = '0;
    return r;
  endfunction

`ifdef AXI_LITE_MEM_ADAPTER_ERR_EN
  // Offset compare avoids overflow of ADDR_BASE+ADDR_SIZE at the top of the map.
  function automatic logic out_of_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a < ADDR_BASE) || ((a - ADDR_BASE) >= ADDR_SIZE);
  endfunction
  assign w_aw_err = out_of_range(slave.aw_addr);
  assign w_ar_err = out_of_range(slave.ar_addr);
`else
  assign w_aw_err = 1'b0;
  assign w_ar_err = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    w_aw_ready = 1'b0;
    w_ar_ready = 1'b0;
    req_o      = 1'b0;
    we_o       = 1'b0;
    addr_o     = '0;
    be_o       = '0;
    wdata_o    = '0;
    case (state_q)
      IDLE: begin
        // Readies and the request strobe are combinational from valid, so
        // they are explicitly held low while reset is asserted.
        if (rst_ni) begin
          if (slave.aw_valid && slave.w_valid) begin
            w_aw_ready = 1'b1;
            id_d       = slave.aw_id;
            resp_d     = w_aw_err ? RESP_SLVERR : RESP_OKAY;
            state_d    = WR_RESP;
            if (!w_aw_err) begin
              req_o   = 1'b1;
              we_o    = 1'b1;
              addr_o  = word_align(slave.aw_addr);
              be_o    = slave.w_strb;
              wdata_o = slave.w_data;
            end
          end else if (slave.ar_valid) begin
            w_ar_ready = 1'b1;
            id_d       = slave.ar_id;
            if (w_ar_err) begin
              resp_d  = RESP_SLVERR;
              rdata_d = '0;
              state_d = RD_RESP;
            end else begin
              resp_d  = RESP_OKAY;
              req_o   = 1'b1;
              addr_o  = word_align(slave.ar_addr);
              be_o    = {STRB_W{1'b1}};
              cnt_d   = 2'(READ_LATENCY - 1);
              state_d = RD_WAIT;
            end
          end
        end
      end
      WR_RESP: begin
        if (slave.b_ready) state_d = IDLE;
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = rdata_i;
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RD_RESP: begin
        if (slave.r_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign slave.aw_ready = w_aw_ready;
  assign slave.w_ready  = w_aw_ready;
  assign slave.ar_ready = w_ar_ready;
  assign slave.b_valid  = (state_q == WR_RESP);
  assign slave.b_id     = id_q;
  assign slave.b_resp   = resp_q;
  assign slave.r_valid  = (state_q == RD_RESP);
  assign slave.r_last   = (state_q == RD_RESP);
  assign slave.r_id     = id_q;
  assign slave.r_data   = rdata_q;
  assign slave.r_resp   = resp_q;

endmodule
`default_nettype wire
